// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per clock, then a sign-fixup cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             r_st,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             signA_q, signA_d;
    logic             signB_q, signB_d;
    logic [WIDTH-1:0] aOrig_q, aOrig_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // accHi/accLo hold the partial product for multiply, or remainder/quotient for divide
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     remShift;
    logic [WIDTH:0]     remDiff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prodFinal;

    assign addSum    = {1'b0, accHi_q} + {1'b0, ({WIDTH{accLo_q[0]}} & opB_q)};
    assign remShift  = {accHi_q, accLo_q[WIDTH-1]};
    assign remDiff   = remShift - {1'b0, opB_q};
    assign prod      = {accHi_q, accLo_q};
    assign prodFinal = (signA_q ^ signB_q) ? -prod : prod;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        signA_d = signA_q;
        signB_d = signB_q;
        aOrig_d = aOrig_q;
        opB_d   = opB_q;
        accHi_d = accHi_q;
        accLo_d = accLo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = A;
                if (lo_we) lo_d = A;
                if (start) begin
                    op_d    = op;
                    signA_d = op[0] & A[WIDTH-1];
                    signB_d = op[0] & B[WIDTH-1];
                    aOrig_d = A;
                    accLo_d = (op[0] & A[WIDTH-1]) ? -A : A;
                    opB_d   = (op[0] & B[WIDTH-1]) ? -B : B;
                    accHi_d = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (op_q[1]) begin
                    // remDiff's top bit is the borrow: set means the trial subtract failed
                    if (!remDiff[WIDTH]) begin
                        accHi_d = remDiff[WIDTH-1:0];
                        accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        accHi_d = remShift[WIDTH-1:0];
                        accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {accHi_d, accLo_d} = {addSum, accLo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = SIGN;
            end
            SIGN: begin
                if (op_q[1]) begin
                    if (opB_q == '0) begin
                        hi_d = aOrig_q;
                        lo_d = '1;
                    end else begin
                        hi_d = signA_q ? -accHi_q : accHi_q;
                        lo_d = (signA_q ^ signB_q) ? -accLo_q : accLo_q;
                    end
                end else begin
                    {hi_d, lo_d} = prodFinal;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (r_st) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            signA_q <= 1'b0;
            signB_q <= 1'b0;
            aOrig_q <= '0;
            opB_q   <= '0;
            accHi_q <= '0;
            accLo_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            signA_q <= signA_d;
            signB_q <= signB_d;
            aOrig_q <= aOrig_d;
            opB_q   <= opB_d;
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        r_st;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .r_st  (r_st),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .HI    (HI),
        .LO    (LO),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {HI, LO} straight from integer arithmetic
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: res = {32'b0, a} * {32'b0, b};
            2'b01: res = sa * sb;
            2'b10: res = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFFFFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic startOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output logic [31:0] h, output logic [31:0] l, output int cyc, output bit timedOut);
        h        = 'x;
        l        = 'x;
        cyc      = 0;
        timedOut = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) begin
                timedOut = 1'b0;
                h = HI;
                l = LO;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        r_st = 1'b1;
        repeat (2) @(negedge clk);
        r_st = 1'b0;
        total++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_hilo: HI=%h LO=%h want 0/0", HI, LO);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_mthi_mtlo();
        int doneSeen = 0;
        @(negedge clk);
        hi_we = 1'b1;
        A     = 32'hDEADBEEF;
        @(negedge clk);
        hi_we = 1'b0;
        if (done === 1'b1) doneSeen++;
        lo_we = 1'b1;
        A     = 32'hCAFEF00D;
        @(negedge clk);
        lo_we = 1'b0;
        if (done === 1'b1) doneSeen++;
        total++;
        if (HI !== 32'hDEADBEEF || LO !== 32'hCAFEF00D) begin
            bad++;
            $display("[TB] FAIL mthi_mtlo: HI=%h LO=%h want DEADBEEF/CAFEF00D", HI, LO);
        end
        hi_we = 1'b1;
        lo_we = 1'b1;
        A     = 32'h13572468;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (done === 1'b1) doneSeen++;
        total++;
        if (HI !== 32'h13572468 || LO !== 32'h13572468) begin
            bad++;
            $display("[TB] FAIL mthi_mtlo_both: HI=%h LO=%h want 13572468/13572468", HI, LO);
        end
        total++;
        if (doneSeen !== 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mthi_no_done: doneSeen=%0d busy=%b want 0/0", doneSeen, busy);
        end
    endtask

    task automatic test_latency();
        int busyErr = 0;
        startOp(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 33; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) busyErr++;
            @(negedge clk);
        end
        total++;
        if (busyErr !== 0) begin
            bad++;
            $display("[TB] FAIL latency_busy: bad cycles=%0d want 0", busyErr);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL latency_done: done=%b busy=%b want 1/0 at E+33", done, busy);
        end
        total++;
        if (HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
            bad++;
            $display("[TB] FAIL latency_result: HI=%h LO=%h want FFFFFFFE/00000001", HI, LO);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL done_pulse_width: done=%b want 0", done);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  vOp [8] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10};
        logic [31:0] vA  [8] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000007, 32'h80000000,
                                 32'h00000007, 32'hFFFFFFF9, 32'h12345678, 32'd100};
        logic [31:0] vB  [8] = '{32'h00000005, 32'h00000002, 32'h00000000, 32'hFFFFFFFF,
                                 32'hFFFFFFFE, 32'h00000000, 32'h00000009, 32'd7};
        logic [31:0] eHi [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007, 32'h00000000,
                                 32'h00000001, 32'hFFFFFFF9, 32'h00000000, 32'h00000002};
        logic [31:0] eLo [8] = '{32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                                 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hA3D70A38, 32'h0000000E};
        logic [31:0] h, l;
        int cyc;
        bit to;
        for (int k = 0; k < 8; k++) begin
            startOp(vOp[k], vA[k], vB[k]);
            waitDone(h, l, cyc, to);
            total++;
            if (to || cyc !== 33) begin
                bad++;
                $display("[TB] FAIL directed_latency[%0d]: timeout=%b cycles=%0d want 33", k, to, cyc);
            end
            total++;
            if (h !== eHi[k] || l !== eLo[k]) begin
                bad++;
                $display("[TB] FAIL directed_result[%0d]: HI=%h LO=%h want %h/%h", k, h, l, eHi[k], eLo[k]);
            end
        end
    endtask

    task automatic test_start_with_write();
        logic [31:0] h, l;
        int cyc;
        bit to;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        A     = 32'd3;
        B     = 32'd4;
        hi_we = 1'b1;
        lo_we = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        total++;
        if (HI !== 32'd3 || LO !== 32'd3 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL start_write_same_cycle: HI=%h LO=%h busy=%b want 3/3/1", HI, LO, busy);
        end
        waitDone(h, l, cyc, to);
        total++;
        if (to || h !== 32'd0 || l !== 32'd12) begin
            bad++;
            $display("[TB] FAIL start_write_overwrite: timeout=%b HI=%h LO=%h want 0/C", to, h, l);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] h, l, prevHi;
        int cyc;
        bit to;
        int busyLater = 0;
        prevHi = HI;
        startOp(2'b10, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        A     = 32'hDEADBEEF;
        B     = 32'd3;
        hi_we = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        total++;
        if (HI !== prevHi || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL busy_ignore_write: HI=%h busy=%b want %h/1", HI, busy, prevHi);
        end
        waitDone(h, l, cyc, to);
        total++;
        if (to || h !== 32'd2 || l !== 32'h0000000E) begin
            bad++;
            $display("[TB] FAIL busy_ignore_result: timeout=%b HI=%h LO=%h want 2/E", to, h, l);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busyLater++;
        end
        total++;
        if (busyLater !== 0) begin
            bad++;
            $display("[TB] FAIL busy_ignore_noqueue: busy cycles=%0d want 0", busyLater);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, h, l;
        logic [1:0]  o;
        logic [63:0] exp;
        int cyc;
        bit to;
        for (int k = 0; k < 60; k++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            exp = refModel(o, a, b);
            startOp(o, a, b);
            repeat ($urandom_range(0, 10)) begin
                @(negedge clk);
                A     = $urandom;
                B     = $urandom;
                start = 1'($urandom_range(0, 1));
                hi_we = 1'($urandom_range(0, 1));
                lo_we = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            start = 1'b0;
            hi_we = 1'b0;
            lo_we = 1'b0;
            waitDone(h, l, cyc, to);
            total++;
            if (to || h !== exp[63:32]) begin
                bad++;
                $display("[TB] FAIL random_hi[%0d] op=%0d a=%h b=%h: timeout=%b HI=%h want %h",
                         k, o, a, b, to, h, exp[63:32]);
            end
            total++;
            if (to || l !== exp[31:0]) begin
                bad++;
                $display("[TB] FAIL random_lo[%0d] op=%0d a=%h b=%h: timeout=%b LO=%h want %h",
                         k, o, a, b, to, l, exp[31:0]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int doneSeen = 0;
        startOp(2'b00, 32'h12345678, 32'd9);
        repeat (9) @(negedge clk);
        r_st = 1'b1;
        @(negedge clk);
        r_st = 1'b0;
        total++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_abort_state: HI=%h LO=%h busy=%b want 0/0/0", HI, LO, busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0) doneSeen++;
            @(negedge clk);
        end
        total++;
        if (doneSeen !== 0) begin
            bad++;
            $display("[TB] FAIL reset_abort_no_done: done cycles=%0d want 0", doneSeen);
        end
    endtask

    initial begin
        r_st  = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'd0;
        B     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        test_reset();
        test_mthi_mtlo();
        test_latency();
        test_directed();
        test_start_with_write();
        test_busy_ignore();
        test_random();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
